// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared encodings and helpers for the mem_access pipeline stage.
//               Memory-op codes, FSM state codes, default address width and
//               the return-address width, plus small op classifiers used by
//               both the FSM and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int DADDR_W_DEF = 16;
    localparam int RA_W        = 14;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_LD8     = 3'd1,
        OP_ST8     = 3'd2,
        OP_LD16    = 3'd3,
        OP_ST16    = 3'd4,
        OP_PUSH_RA = 3'd5,
        OP_POP_RA  = 3'd6,
        OP_RSVD    = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Code 7 is reserved and behaves exactly like NONE.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction

    function automatic logic is_two_byte(input logic [2:0] op);
        return (op == OP_LD16) || (op == OP_ST16) ||
               (op == OP_PUSH_RA) || (op == OP_POP_RA);
    endfunction

    function automatic logic is_write(input logic [2:0] op);
        return (op == OP_ST8) || (op == OP_ST16) || (op == OP_PUSH_RA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_fsm
// Description : Sequencing for the memory stage: state register, next-state
//               logic and (optionally) the ack watchdog counter.
//               Optional feature macro: MEM_ACCESS_TIMEOUT_EN
// Ports       : clock, nreset    - clock, synchronous active-low reset
//               mem_op           - decoded memory op (held while stalled)
//               dmem_ack         - data-memory access complete
//               state            - current state (mem_state_e encoding)
//               timeout          - watchdog expiry, acts as a forced ack
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_fsm
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic [2:0] mem_op,
    input  logic       dmem_ack,
    output logic [1:0] state,
    output logic       timeout
);

    mem_state_e r_state;
    mem_state_e w_next_state;
    logic       w_beat_done;

    assign state       = r_state;
    assign w_beat_done = dmem_ack | timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] C_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;
    logic       w_in_acc;

    assign w_in_acc = (r_state == ST_ACC0) || (r_state == ST_ACC1);
    assign timeout  = w_in_acc && !dmem_ack && (r_wait_cnt == C_LIMIT);

    // Counter sits at zero outside the access states and is cleared by each
    // completed beat, so it always starts from zero on entry to ACC0/ACC1.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_wait_cnt <= 8'd0;
        end else if (!w_in_acc || w_beat_done) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    // Watchdog compiled out: constant 0 for any legal limit, the access
    // waits for ack indefinitely.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (is_mem_op(mem_op)) begin
                    w_next_state = ST_ACC0;
                end
            end
            ST_ACC0: begin
                if (w_beat_done) begin
                    w_next_state = is_two_byte(mem_op) ? ST_ACC1 : ST_DONE;
                end
            end
            ST_ACC1: begin
                if (w_beat_done) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory pipeline stage of the 8-bit core. Performs byte and
//               two-byte loads/stores and return-address push/pop over a
//               req/ack data-memory port, stalling upstream while an access
//               is in flight and presenting one result beat to mem_wb.
//               Non-memory ops pass through combinationally.
//               Optional feature macro: MEM_ACCESS_TIMEOUT_EN (ack watchdog,
//               sticky mem_fault).
// Ports       : clock, nreset          - clock, sync active-low reset
//               mem_op_in .. ret_addr_in - operands from ex_mem (held stable
//                                        by upstream while stall_out=1)
//               *_out                  - result beat towards mem_wb
//               stall_out              - freeze ex_mem and upstream
//               dmem_*                 - data-memory req/ack port
//               mem_fault              - sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_pkg::*;
#(
    parameter int DADDR_W        = DADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic [2:0]          mem_op_in,
    input  logic [DADDR_W-1:0]  addr_in,
    input  logic [7:0]          data_top_in,
    input  logic [7:0]          data_bot_in,
    input  logic [31:0]         instruction_in,
    input  logic [1:0]          reg_file_wen_in,
    input  logic [RA_W-1:0]     ret_addr_in,
    output logic [7:0]          data_top_out,
    output logic [7:0]          data_bot_out,
    output logic [31:0]         instruction_out,
    output logic [1:0]          reg_file_wen_out,
    output logic [RA_W-1:0]     ret_addr_out,
    output logic                stall_out,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DADDR_W-1:0]  dmem_addr,
    output logic [7:0]          dmem_wdata,
    input  logic [7:0]          dmem_rdata,
    input  logic                dmem_ack,
    output logic                mem_fault
);

    logic [1:0]         w_state_bits;
    mem_state_e         w_state;
    mem_op_e            w_op;
    logic               w_timeout;
    logic               w_beat_done;
    logic [7:0]         w_rdata;
    logic [DADDR_W-1:0] w_addr_hi;

    logic [7:0]         r_cap_top;
    logic [7:0]         r_cap_bot;
    logic [RA_W-1:0]    r_cap_ra;

    mem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clock    (clock),
        .nreset   (nreset),
        .mem_op   (mem_op_in),
        .dmem_ack (dmem_ack),
        .state    (w_state_bits),
        .timeout  (w_timeout)
    );

    assign w_state     = mem_state_e'(w_state_bits);
    assign w_op        = mem_op_e'(mem_op_in);
    assign w_beat_done = dmem_ack | w_timeout;
    // A watchdog expiry completes the beat with all-ones read data.
    assign w_rdata     = w_timeout ? 8'hFF : dmem_rdata;
    // Second byte address wraps naturally at the top of the address space.
    assign w_addr_hi   = addr_in + {{(DADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Capture registers. Acks outside ACC0/ACC1 never reach here because
    // the case only acts in those states.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_cap_top <= 8'h00;
            r_cap_bot <= 8'h00;
            r_cap_ra  <= '0;
        end else if (w_beat_done) begin
            case (w_state)
                ST_ACC0: begin
                    if ((w_op == OP_LD8) || (w_op == OP_LD16)) begin
                        r_cap_top <= w_rdata;
                    end else if (w_op == OP_POP_RA) begin
                        // Upper two bits of the stored byte fall outside RA_W.
                        r_cap_ra[RA_W-1:8] <= w_rdata[RA_W-9:0];
                    end
                end
                ST_ACC1: begin
                    if (w_op == OP_LD16) begin
                        r_cap_bot <= w_rdata;
                    end else if (w_op == OP_POP_RA) begin
                        r_cap_ra[7:0] <= w_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic r_mem_fault;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_mem_fault <= 1'b0;
        end else if (w_timeout) begin
            r_mem_fault <= 1'b1;
        end
    end

    assign mem_fault = r_mem_fault;
`else
    assign mem_fault = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output muxing. Defaults are the pass-through/idle values; while in
    // reset the state is ignored so stall and req drop immediately.
    // ------------------------------------------------------------------
    always_comb begin
        data_top_out     = data_top_in;
        data_bot_out     = data_bot_in;
        instruction_out  = instruction_in;
        reg_file_wen_out = reg_file_wen_in;
        ret_addr_out     = ret_addr_in;
        stall_out        = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        dmem_addr        = addr_in;
        dmem_wdata       = data_top_in;

        if (nreset) begin
            case (w_state)
                ST_IDLE: begin
                    if (is_mem_op(mem_op_in)) begin
                        stall_out        = 1'b1;
                        instruction_out  = 32'h0;
                        reg_file_wen_out = 2'b00;
                    end
                end
                ST_ACC0: begin
                    stall_out        = 1'b1;
                    instruction_out  = 32'h0;
                    reg_file_wen_out = 2'b00;
                    dmem_req         = 1'b1;
                    dmem_we          = is_write(mem_op_in);
                    dmem_addr        = addr_in;
                    dmem_wdata       = (w_op == OP_PUSH_RA) ?
                                       {2'b00, ret_addr_in[RA_W-1:8]} : data_top_in;
                end
                ST_ACC1: begin
                    stall_out        = 1'b1;
                    instruction_out  = 32'h0;
                    reg_file_wen_out = 2'b00;
                    dmem_req         = 1'b1;
                    dmem_we          = is_write(mem_op_in);
                    dmem_addr        = w_addr_hi;
                    dmem_wdata       = (w_op == OP_PUSH_RA) ?
                                       ret_addr_in[7:0] : data_bot_in;
                end
                ST_DONE: begin
                    if ((w_op == OP_LD8) || (w_op == OP_LD16)) begin
                        data_top_out = r_cap_top;
                    end
                    if (w_op == OP_LD16) begin
                        data_bot_out = r_cap_bot;
                    end
                    if (w_op == OP_POP_RA) begin
                        ret_addr_out = r_cap_ra;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access. A bench-side memory
//               answers the DUT's requests with chosen wait times; expected
//               outputs for every cycle come from the op semantics and that
//               memory. Directed cases first, then randomized ops.
//               Optional feature macro: MEM_ACCESS_TIMEOUT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int TO = 64;

    logic        clock = 1'b0;
    logic        nreset;
    logic [2:0]  mem_op_in;
    logic [15:0] addr_in;
    logic [7:0]  data_top_in, data_bot_in;
    logic [31:0] instruction_in;
    logic [1:0]  reg_file_wen_in;
    logic [13:0] ret_addr_in;
    logic [7:0]  data_top_out, data_bot_out;
    logic [31:0] instruction_out;
    logic [1:0]  reg_file_wen_out;
    logic [13:0] ret_addr_out;
    logic        stall_out, dmem_req, dmem_we, dmem_ack, mem_fault;
    logic [15:0] dmem_addr;
    logic [7:0]  dmem_wdata, dmem_rdata;

    always #5 clock = ~clock;

    mem_access #(
        .DADDR_W        (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .nreset           (nreset),
        .mem_op_in        (mem_op_in),
        .addr_in          (addr_in),
        .data_top_in      (data_top_in),
        .data_bot_in      (data_bot_in),
        .instruction_in   (instruction_in),
        .reg_file_wen_in  (reg_file_wen_in),
        .ret_addr_in      (ret_addr_in),
        .data_top_out     (data_top_out),
        .data_bot_out     (data_bot_out),
        .instruction_out  (instruction_out),
        .reg_file_wen_out (reg_file_wen_out),
        .ret_addr_out     (ret_addr_out),
        .stall_out        (stall_out),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .mem_fault        (mem_fault)
    );

    // Bench-side data memory.
    logic [7:0] mem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    // Expected behaviour for the current cycle.
    // mode 0: no check, 1: in reset, 2: result/pass-through beat, 3: stalled
    int          exp_mode = 0;
    logic        exp_req, exp_we, exp_fault;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata, exp_top, exp_bot;
    logic [31:0] exp_instr;
    logic [1:0]  exp_wen;
    logic [13:0] exp_ret;

    // Hand-computed literal expectations.
    logic        lit_top_en = 1'b0, lit_ret_en = 1'b0, lit_mem_en = 1'b0;
    logic [7:0]  lit_top, lit_mem_val;
    logic [13:0] lit_ret;
    logic [15:0] lit_mem_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_mode != 0) begin
            chk("stall", 32'(stall_out), 32'(exp_mode == 3));
            chk("req", 32'(dmem_req), 32'((exp_mode == 3) && exp_req));
            chk("fault", 32'(mem_fault), 32'(exp_fault));
            if (exp_mode == 2) begin
                chk("top", 32'(data_top_out), 32'(exp_top));
                chk("bot", 32'(data_bot_out), 32'(exp_bot));
                chk("instr", instruction_out, exp_instr);
                chk("wen", 32'(reg_file_wen_out), 32'(exp_wen));
                chk("ret", 32'(ret_addr_out), 32'(exp_ret));
                if (lit_top_en) chk("lit_top", 32'(data_top_out), 32'(lit_top));
                if (lit_ret_en) chk("lit_ret", 32'(ret_addr_out), 32'(lit_ret));
            end
            if (exp_mode == 3) begin
                chk("instr_bubble", instruction_out, 32'h0);
                chk("wen_bubble", 32'(reg_file_wen_out), 32'h0);
                if (exp_req) begin
                    chk("addr", 32'(dmem_addr), 32'(exp_addr));
                    chk("we", 32'(dmem_we), 32'(exp_we));
                    if (exp_we) chk("wdata", 32'(dmem_wdata), 32'(exp_wdata));
                end
            end
            if (lit_mem_en) chk("lit_mem", 32'(mem[lit_mem_addr]), 32'(lit_mem_val));
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic noise();
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = 8'($urandom);
    endtask

    // One instruction: issue cycle, memory beats with d0/d1 wait cycles
    // before ack, then the result cycle.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a,
                          input logic [7:0] t, input logic [7:0] b,
                          input logic [31:0] ins, input logic [1:0] w,
                          input logic [13:0] r, input int d0, input int d1);
        logic [7:0]  rd [2];
        logic [15:0] ba;
        logic        wr_op, ack_now, to_now;
        int          nb, d, k;
        mem_op_in = op; addr_in = a; data_top_in = t; data_bot_in = b;
        instruction_in = ins; reg_file_wen_in = w; ret_addr_in = r;
        noise();
        if (op == 3'd0 || op == 3'd7) begin
            exp_mode = 2; exp_top = t; exp_bot = b; exp_instr = ins;
            exp_wen = w; exp_ret = r;
            next_cycle();
            return;
        end
        exp_mode = 3; exp_req = 1'b0;
        next_cycle();
        wr_op = (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
        nb    = (op == 3'd1 || op == 3'd2) ? 1 : 2;
        rd[0] = t; rd[1] = b;
        for (int bt = 0; bt < nb; bt++) begin
            d  = (bt == 0) ? d0 : d1;
            ba = a + 16'(bt);
            exp_req = 1'b1; exp_addr = ba; exp_we = wr_op;
            if (op == 3'd5) exp_wdata = (bt == 0) ? {2'b00, r[13:8]} : r[7:0];
            else            exp_wdata = (bt == 0) ? t : b;
            k = 0;
            while (1) begin
                ack_now = (k == d);
                to_now  = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                if (!ack_now && k == TO - 1) to_now = 1'b1;
`endif
                dmem_ack   = ack_now;
                dmem_rdata = ack_now ? mem[ba] : 8'($urandom);
                @(negedge clock);
                if (ack_now && !wr_op) rd[bt] = mem[ba];
                if (ack_now && wr_op && dmem_req && dmem_we) mem[dmem_addr] = dmem_wdata;
                if (to_now) rd[bt] = 8'hFF;
                @(posedge clock);
                #1;
                if (to_now) exp_fault = 1'b1;
                if (ack_now || to_now) break;
                k++;
            end
        end
        exp_mode  = 2;
        exp_instr = ins; exp_wen = w;
        exp_top   = (op == 3'd1 || op == 3'd3) ? rd[0] : t;
        exp_bot   = (op == 3'd3) ? rd[1] : b;
        exp_ret   = (op == 3'd6) ? {rd[0][5:0], rd[1]} : r;
        noise();
        next_cycle();
    endtask

    task automatic nop_cycle();
        run_op(3'd0, 16'($urandom), 8'($urandom), 8'($urandom), $urandom,
               2'($urandom), 14'($urandom), 0, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'hA5;

        // Reset with a memory op presented: stall/req forced low.
        nreset = 1'b0; exp_fault = 1'b0;
        mem_op_in = 3'd1; addr_in = 16'h0100; data_top_in = 8'h00; data_bot_in = 8'h00;
        instruction_in = 32'h0; reg_file_wen_in = 2'b00; ret_addr_in = 14'h0;
        dmem_ack = 1'b0; dmem_rdata = 8'h00;
        exp_mode = 1;
        next_cycle();
        next_cycle();
        nreset = 1'b1;

        // NONE pass-through.
        run_op(3'd0, 16'h1234, 8'h3C, 8'h5A, 32'hDEADBEEF, 2'b01, 14'h0123, 0, 0);
        // LD8 with two wait cycles.
        lit_top_en = 1'b1; lit_top = 8'hA5;
        run_op(3'd1, 16'h0100, 8'h00, 8'h77, 32'h11110001, 2'b01, 14'h0001, 2, 0);
        lit_top_en = 1'b0;
        // ST16 wrapping at the top of memory.
        run_op(3'd4, 16'hFFFF, 8'h12, 8'h34, 32'h22220002, 2'b00, 14'h0002, 0, 0);
        lit_mem_en = 1'b1; lit_mem_addr = 16'hFFFF; lit_mem_val = 8'h12; nop_cycle();
        lit_mem_addr = 16'h0000; lit_mem_val = 8'h34; nop_cycle();
        // PUSH_RA then POP_RA.
        run_op(3'd5, 16'h0040, 8'h00, 8'h00, 32'h33330003, 2'b00, 14'h2ABC, 1, 0);
        lit_mem_addr = 16'h0040; lit_mem_val = 8'h2A; nop_cycle();
        lit_mem_addr = 16'h0041; lit_mem_val = 8'hBC; nop_cycle();
        lit_mem_en = 1'b0;
        lit_ret_en = 1'b1; lit_ret = 14'h2ABC;
        run_op(3'd6, 16'h0040, 8'h00, 8'h00, 32'h44440004, 2'b10, 14'h0000, 0, 1);
        lit_ret_en = 1'b0;

        // Reset during the second beat of LD16.
        mem_op_in = 3'd3; addr_in = 16'h0200; dmem_ack = 1'b0;
        exp_mode = 3; exp_req = 1'b0;
        next_cycle();
        exp_req = 1'b1; exp_addr = 16'h0200; exp_we = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = mem[16'h0200];
        next_cycle();
        exp_addr = 16'h0201; dmem_ack = 1'b0;
        next_cycle();
        nreset = 1'b0; exp_mode = 1;
        next_cycle();
        nreset = 1'b1;
        nop_cycle();
        run_op(3'd7, 16'h0300, 8'h9C, 8'h1E, 32'h55550005, 2'b11, 14'h1555, 0, 0);

        // Randomized ops.
        for (int n = 0; n < 250; n++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a = 16'hFFFF - 16'($urandom_range(0, 1));
            else                           a = 16'($urandom_range(0, 63));
            run_op(op, a, 8'($urandom), 8'($urandom), $urandom, 2'($urandom),
                   14'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No ack at all: watchdog completes the load with 8'hFF.
        lit_top_en = 1'b1; lit_top = 8'hFF;
        run_op(3'd1, 16'h0500, 8'h00, 8'h00, 32'h66660006, 2'b01, 14'h0, 1000, 0);
        lit_top_en = 1'b0;
        nop_cycle();
        nop_cycle();
        nreset = 1'b0; exp_mode = 1;
        next_cycle();
        nreset = 1'b1; exp_fault = 1'b0;
        nop_cycle();
`endif

        exp_mode = 0;
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
